// File: rtl/udp_pkg.sv
// Shared constants, FSM state type and one's-complement helper for the UDP checksum engine.
package udp_pkg;

   localparam logic [7:0]  IP_PROTO_UDP = 8'h11;
   localparam logic [15:0] MAX_UDP_LEN  = 16'hFFFF;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ACCUM  = 3'd1,
      PSEUDO = 3'd2,
      FOLD1  = 3'd3,
      FOLD2  = 3'd4,
      DONE   = 3'd5
   } udp_state_t;

   // 16-bit add with the carry wrapped back into bit 0
   function automatic logic [15:0] csum_add16(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[15:0] + {15'd0, sum[16]};
   endfunction

endpackage

// File: rtl/udp_csum_beat_sum.sv
// Combinational partial sum of one beat: kept bytes placed high/low by stream-offset parity.
module udp_csum_beat_sum
   import udp_pkg::*;
#(
   parameter int BYTES_PER_BEAT = 1
) (
   input  logic [8*BYTES_PER_BEAT-1:0] i_data,
   input  logic [BYTES_PER_BEAT-1:0]   i_keep,
   input  logic                        i_parity,
   output logic [18:0]                 o_sum,
   output logic [3:0]                  o_count,
   output logic                        o_parity
);

   logic [18:0] w_sum;
   logic [3:0]  w_cnt;
   logic [7:0]  w_byte;

   // Lane 0 sits in the MSBs; keep is contiguous from the MSB lane, so lane parity alternates
   always_comb begin
      w_sum  = 19'd0;
      w_cnt  = 4'd0;
      w_byte = 8'h00;
      for (int i = 0; i < BYTES_PER_BEAT; i++) begin
         w_byte = i_data[8*(BYTES_PER_BEAT-i)-1 -: 8];
         if (i_keep[BYTES_PER_BEAT-1-i]) begin
            if ((i_parity ^ i[0]) == 1'b0) begin
               w_sum = w_sum + {3'd0, w_byte, 8'h00};
            end else begin
               w_sum = w_sum + {11'd0, w_byte};
            end
            w_cnt = w_cnt + 4'd1;
         end else begin
            w_sum = w_sum;
         end
      end
   end

   assign o_sum    = w_sum;
   assign o_count  = w_cnt;
   assign o_parity = i_parity ^ w_cnt[0];

endmodule

// File: rtl/udp_csum_engine.sv
// Streaming UDP checksum engine (generate/verify) over a configurable byte-lane stream.
// Define UDP_CSUM_PSEUDO_HDR_EN to add the IPv4 pseudo-header (src_ip/dst_ip ports, PSEUDO state).
module udp_csum_engine
   import udp_pkg::*;
#(
   parameter int BYTES_PER_BEAT = 1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        mode,
   input  logic [8*BYTES_PER_BEAT-1:0] in_data,
   input  logic [BYTES_PER_BEAT-1:0]   in_keep,
   input  logic                        in_valid,
   input  logic                        in_first,
   input  logic                        in_last,
   output logic                        in_ready,
`ifdef UDP_CSUM_PSEUDO_HDR_EN
   input  logic [31:0]                 src_ip,
   input  logic [31:0]                 dst_ip,
`endif
   output logic                        result_valid,
   output logic [15:0]                 result_csum,
   output logic                        result_ok,
   output logic [15:0]                 result_len
);

`ifdef UDP_CSUM_PSEUDO_HDR_EN
   localparam udp_state_t AFTER_LAST = PSEUDO;
   logic [31:0] r_src;
   logic [31:0] r_dst;
   logic [31:0] w_pseudo;
`else
   localparam udp_state_t AFTER_LAST = FOLD1;
`endif

   udp_state_t  r_state;
   udp_state_t  w_next_state;
   logic [31:0] r_acc;
   logic [15:0] r_count;
   logic        r_parity;
   logic        r_ovf;
   logic        r_mode;
   logic        r_in_ready;
   logic        r_res_valid;
   logic [15:0] r_res_csum;
   logic        r_res_ok;
   logic [15:0] r_res_len;

   logic        w_accept;
   logic        w_start;
   logic        w_cont;
   logic        w_par_in;
   logic        w_par_out;
   logic [18:0] w_beat_sum;
   logic [3:0]  w_beat_cnt;
   logic [16:0] w_cnt_sum;
   logic [16:0] w_fold1;
   logic [15:0] w_sum16;
   logic [15:0] w_inv;

   assign w_accept = in_valid & r_in_ready;
   assign w_start  = w_accept & in_first;
   assign w_cont   = w_accept & ~in_first & (r_state == ACCUM);
   assign w_par_in = in_first ? 1'b0 : r_parity;

   udp_csum_beat_sum #(.BYTES_PER_BEAT(BYTES_PER_BEAT)) u_beat_sum (
      .i_data   (in_data),
      .i_keep   (in_keep),
      .i_parity (w_par_in),
      .o_sum    (w_beat_sum),
      .o_count  (w_beat_cnt),
      .o_parity (w_par_out)
   );

   assign w_cnt_sum = {1'b0, r_count} + {13'd0, w_beat_cnt};
   assign w_fold1   = {1'b0, r_acc[15:0]} + {1'b0, r_acc[31:16]};
   assign w_sum16   = csum_add16(r_acc[15:0], r_acc[31:16]);
   assign w_inv     = ~w_sum16;
`ifdef UDP_CSUM_PSEUDO_HDR_EN
   assign w_pseudo  = {16'd0, r_src[31:16]} + {16'd0, r_src[15:0]} + {16'd0, r_dst[31:16]}
                    + {16'd0, r_dst[15:0]} + {24'd0, IP_PROTO_UDP} + {16'd0, r_count};
`endif

   // Next-state logic; a first beat always (re)starts a frame, aborting any open one
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE, ACCUM: begin
            if (w_start || w_cont) begin
               if (in_last) begin
                  w_next_state = AFTER_LAST;
               end else begin
                  w_next_state = ACCUM;
               end
            end else begin
               w_next_state = r_state;
            end
         end
`ifdef UDP_CSUM_PSEUDO_HDR_EN
         PSEUDO:  w_next_state = FOLD1;
`endif
         FOLD1:   w_next_state = FOLD2;
         FOLD2:   w_next_state = DONE;
         DONE:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // State, accumulator and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_in_ready  <= 1'b0;
         r_acc       <= 32'd0;
         r_count     <= 16'd0;
         r_parity    <= 1'b0;
         r_ovf       <= 1'b0;
         r_mode      <= 1'b0;
`ifdef UDP_CSUM_PSEUDO_HDR_EN
         r_src       <= 32'd0;
         r_dst       <= 32'd0;
`endif
         r_res_valid <= 1'b0;
         r_res_csum  <= 16'h0000;
         r_res_ok    <= 1'b0;
         r_res_len   <= 16'h0000;
      end else begin
         r_state     <= w_next_state;
         r_in_ready  <= (w_next_state == IDLE) || (w_next_state == ACCUM);
         r_res_valid <= 1'b0;
         case (r_state)
            IDLE, ACCUM: begin
               if (w_start) begin
                  r_acc    <= {13'd0, w_beat_sum};
                  r_count  <= {12'd0, w_beat_cnt};
                  r_parity <= w_par_out;
                  r_ovf    <= 1'b0;
                  r_mode   <= mode;
`ifdef UDP_CSUM_PSEUDO_HDR_EN
                  r_src    <= src_ip;
                  r_dst    <= dst_ip;
`endif
               end else if (w_cont) begin
                  r_acc    <= r_acc + {13'd0, w_beat_sum};
                  r_count  <= w_cnt_sum[16] ? MAX_UDP_LEN : w_cnt_sum[15:0];
                  r_ovf    <= r_ovf | w_cnt_sum[16];
                  r_parity <= w_par_out;
               end else begin
                  r_acc    <= r_acc;
               end
            end
`ifdef UDP_CSUM_PSEUDO_HDR_EN
            PSEUDO: r_acc <= r_acc + w_pseudo;
`endif
            FOLD1:  r_acc <= {15'd0, w_fold1};
            FOLD2: begin
               r_res_valid <= 1'b1;
               r_res_len   <= r_count;
               if (r_mode) begin
                  r_res_csum <= w_inv;
                  r_res_ok   <= (w_sum16 == 16'hFFFF) && !r_ovf;
               end else begin
                  // 0x0000 means "no checksum" on the wire, so send its one's-complement twin
                  r_res_csum <= (w_inv == 16'h0000) ? 16'hFFFF : w_inv;
                  r_res_ok   <= !r_ovf;
               end
            end
            default: r_acc <= r_acc;
         endcase
      end
   end

   assign in_ready     = r_in_ready;
   assign result_valid = r_res_valid;
   assign result_csum  = r_res_csum;
   assign result_ok    = r_res_ok;
   assign result_len   = r_res_len;

endmodule

// File: tb/tb_udp_csum_engine.sv
// Bench for udp_csum_engine: two instances (1 and 4 byte lanes), table vectors, random frames, corner sequences.
module tb_udp_csum_engine;

`ifdef UDP_CSUM_PSEUDO_HDR_EN
   localparam int LAT = 4;
`else
   localparam int LAT = 3;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        sel = 1'b0, t_valid = 1'b0, t_first = 1'b0, t_last = 1'b0, t_mode = 1'b0;
   logic [7:0]  d1 = 8'h00;
   logic        k1 = 1'b0;
   logic [31:0] d4 = 32'h0;
   logic [3:0]  k4 = 4'h0;
`ifdef UDP_CSUM_PSEUDO_HDR_EN
   logic [31:0] src_ip = 32'h0A000001;
   logic [31:0] dst_ip = 32'h0A000002;
`endif
   logic        rdy1, rv1, ok1, rdy4, rv4, ok4;
   logic [15:0] cs1, len1, cs4, len4;
   logic        v1, v4, rdy_m, rv_m, ok_m;
   logic [15:0] cs_m, len_m;

   assign v1    = t_valid & ~sel;
   assign v4    = t_valid & sel;
   assign rdy_m = sel ? rdy4 : rdy1;
   assign rv_m  = sel ? rv4  : rv1;
   assign ok_m  = sel ? ok4  : ok1;
   assign cs_m  = sel ? cs4  : cs1;
   assign len_m = sel ? len4 : len1;

   udp_csum_engine #(.BYTES_PER_BEAT(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .mode(t_mode), .in_data(d1), .in_keep(k1),
      .in_valid(v1), .in_first(t_first), .in_last(t_last), .in_ready(rdy1),
`ifdef UDP_CSUM_PSEUDO_HDR_EN
      .src_ip(src_ip), .dst_ip(dst_ip),
`endif
      .result_valid(rv1), .result_csum(cs1), .result_ok(ok1), .result_len(len1)
   );

   udp_csum_engine #(.BYTES_PER_BEAT(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .mode(t_mode), .in_data(d4), .in_keep(k4),
      .in_valid(v4), .in_first(t_first), .in_last(t_last), .in_ready(rdy4),
`ifdef UDP_CSUM_PSEUDO_HDR_EN
      .src_ip(src_ip), .dst_ip(dst_ip),
`endif
      .result_valid(rv4), .result_csum(cs4), .result_ok(ok4), .result_len(len4)
   );

   int n_checks = 0;
   int n_errors = 0;
   int pc1 = 0;
   int pc4 = 0;
   logic [7:0] frame_q[$];

   always @(posedge clk) begin
      if (rv1) pc1 <= pc1 + 1;
      if (rv4) pc4 <= pc4 + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Reference: RFC 1071 sum over the byte list (plus pseudo-header), folded with plain arithmetic
   function automatic logic [15:0] ref_sum();
      longint s = 0;
      int n = frame_q.size();
      for (int i = 0; i < n; i++)
         s += (i % 2 == 0) ? longint'(frame_q[i]) * 256 : longint'(frame_q[i]);
`ifdef UDP_CSUM_PSEUDO_HDR_EN
      s += longint'(src_ip[31:16]) + longint'(src_ip[15:0]) + longint'(dst_ip[31:16])
         + longint'(dst_ip[15:0]) + 17 + ((n > 65535) ? 65535 : n);
`endif
      while (s > 65535) s = (s % 65536) + (s / 65536);
      return 16'(s);
   endfunction

   task automatic expect_model(input logic md, output logic [15:0] ec, output logic eok,
                               output logic [15:0] el);
      logic [15:0] s;
      int n;
      s  = ref_sum();
      n  = frame_q.size();
      el = (n > 65535) ? 16'hFFFF : 16'(n);
      if (md) begin
         ec  = ~s;
         eok = (s == 16'hFFFF) && (n <= 65535);
      end else begin
         ec  = (s == 16'hFFFF) ? 16'hFFFF : ~s;
         eok = (n <= 65535);
      end
   endtask

   task automatic send_frame(input logic s, input logic md, input int max_beats);
      int w, nb, ns, tries, n;
      n  = frame_q.size();
      w  = s ? 4 : 1;
      nb = (n + w - 1) / w;
      ns = (max_beats >= 0 && max_beats < nb) ? max_beats : nb;
      sel = s;
      for (int b = 0; b < ns; b++) begin
         @(negedge clk);
         t_valid = 1'b1; t_first = (b == 0); t_last = (b == nb - 1); t_mode = md;
         d1 = (b < n) ? frame_q[b] : 8'h00;
         k1 = 1'b1;
         d4 = 32'h0; k4 = 4'h0;
         for (int l = 0; l < 4; l++) begin
            if (b * 4 + l < n) begin
               d4[31-8*l -: 8] = frame_q[b*4+l];
               k4[3-l] = 1'b1;
            end
         end
         tries = 0;
         while (!rdy_m && tries < 50) begin
            @(negedge clk);
            tries++;
         end
         if (tries >= 50) begin
            n_checks++; n_errors++;
            $display("FAIL ready_timeout actual=0 expected=1");
         end
         @(posedge clk);
      end
      @(negedge clk);
      t_valid = 1'b0; t_first = 1'b0; t_last = 1'b0;
   endtask

   // Entered at the first falling edge after the last beat was accepted
   task automatic wait_result(input logic [15:0] ec, input logic eok, input logic [15:0] el,
                              input string tag);
      int n = 1;
      check({tag, "_busy_ready"}, rdy_m, 0);
      while (!rv_m && n < 12) begin
         @(negedge clk);
         n++;
      end
      if (!rv_m) begin
         n_checks++; n_errors++;
         $display("FAIL %s_result_timeout actual=0 expected=1", tag);
      end else begin
         check({tag, "_latency"}, n, LAT);
         check({tag, "_csum"}, cs_m, ec);
         check({tag, "_ok"}, ok_m, eok);
         check({tag, "_len"}, len_m, el);
         @(negedge clk);
         check({tag, "_pulse"}, rv_m, 0);
         check({tag, "_hold"}, cs_m, ec);
      end
   endtask

   typedef struct {
      logic            s;
      logic            md;
      int              n;
      logic [0:11][7:0] b;
      logic [15:0]     csum;
      logic            ok;
      logic [15:0]     len;
   } vec_t;

   localparam logic [63:0] P8 = 64'h0001_F203_F4F5_F6F7;

   initial begin
      vec_t        tbl[$];
      logic [15:0] ec, el, s16;
      logic        eok, rs, rm;
      int          rn, p0;

`ifdef UDP_CSUM_PSEUDO_HDR_EN
      tbl.push_back('{1'b0, 1'b0, 8, {P8, 32'h0}, 16'h0DF1, 1'b1, 16'd8});
      tbl.push_back('{1'b1, 1'b0, 8, {P8, 32'h0}, 16'h0DF1, 1'b1, 16'd8});
      tbl.push_back('{1'b1, 1'b0, 8, 96'h0, 16'hEBE3, 1'b1, 16'd8});
      tbl.push_back('{1'b0, 1'b0, 8, 96'h0, 16'hEBE3, 1'b1, 16'd8});
`else
      tbl.push_back('{1'b0, 1'b0, 8, {P8, 32'h0}, 16'h220D, 1'b1, 16'd8});
      tbl.push_back('{1'b1, 1'b0, 8, {P8, 32'h0}, 16'h220D, 1'b1, 16'd8});
      tbl.push_back('{1'b0, 1'b1, 10, {P8, 16'h220D, 16'h0}, 16'h0000, 1'b1, 16'd10});
      tbl.push_back('{1'b1, 1'b1, 10, {P8, 16'h220D, 16'h0}, 16'h0000, 1'b1, 16'd10});
      tbl.push_back('{1'b1, 1'b1, 10, {P8, 16'h220E, 16'h0}, 16'hFFFE, 1'b0, 16'd10});
      tbl.push_back('{1'b0, 1'b1, 10, {P8, 16'h220E, 16'h0}, 16'hFFFE, 1'b0, 16'd10});
      tbl.push_back('{1'b1, 1'b0, 3, {24'h010203, 72'h0}, 16'hFBFD, 1'b1, 16'd3});
      tbl.push_back('{1'b0, 1'b0, 3, {24'h010203, 72'h0}, 16'hFBFD, 1'b1, 16'd3});
      tbl.push_back('{1'b1, 1'b0, 2, {16'hFFFF, 80'h0}, 16'hFFFF, 1'b1, 16'd2});
`endif

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready1", rdy1, 0);
      check("rst_ready4", rdy4, 0);
      check("rst_valid", rv1, 0);
      check("rst_csum", cs4, 0);
      check("rst_ok", ok1, 0);
      check("rst_len", len4, 0);
      @(negedge clk) rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_ready1", rdy1, 1);
      check("idle_ready4", rdy4, 1);

      // Table vectors
      foreach (tbl[i]) begin
         frame_q.delete();
         for (int j = 0; j < tbl[i].n; j++) frame_q.push_back(tbl[i].b[j]);
         send_frame(tbl[i].s, tbl[i].md, -1);
         wait_result(tbl[i].csum, tbl[i].ok, tbl[i].len, $sformatf("vec%0d", i));
      end

      // Random frames against the model; half of the verify frames carry a correct checksum
      for (int r = 0; r < 30; r++) begin
         rs = 1'($urandom_range(0, 1));
         rm = 1'($urandom_range(0, 1));
         rn = int'($urandom_range(1, 40));
`ifdef UDP_CSUM_PSEUDO_HDR_EN
         src_ip = $urandom;
         dst_ip = $urandom;
`endif
         frame_q.delete();
         for (int j = 0; j < rn; j++) frame_q.push_back(8'($urandom_range(0, 255)));
         if (rm && ($urandom_range(0, 1) == 1)) begin
            if (rn % 2 == 1) frame_q.push_back(8'($urandom_range(0, 255)));
            frame_q.push_back(8'h00);
            frame_q.push_back(8'h00);
            s16 = ~ref_sum();
            frame_q[frame_q.size()-2] = s16[15:8];
            frame_q[frame_q.size()-1] = s16[7:0];
         end
         expect_model(rm, ec, eok, el);
         send_frame(rs, rm, -1);
         wait_result(ec, eok, el, $sformatf("rnd%0d", r));
      end

      // Abort: first frame cut short by a new in_first; only the second frame reports
      p0 = pc4;
      frame_q.delete();
      for (int j = 0; j < 12; j++) frame_q.push_back(8'($urandom_range(0, 255)));
      send_frame(1'b1, 1'b0, 2);
      frame_q.delete();
      for (int j = 0; j < 9; j++) frame_q.push_back(8'($urandom_range(0, 255)));
      expect_model(1'b0, ec, eok, el);
      send_frame(1'b1, 1'b0, -1);
      wait_result(ec, eok, el, "abort");
      repeat (4) @(negedge clk);
      check("abort_pulses", pc4 - p0, 1);

      // A beat without in_first while idle is dropped
      p0 = pc1;
      @(negedge clk);
      sel = 1'b0; t_valid = 1'b1; t_first = 1'b0; t_last = 1'b1; d1 = 8'h55;
      @(negedge clk);
      t_valid = 1'b0; t_last = 1'b0;
      repeat (6) @(negedge clk);
      check("stray_pulses", pc1 - p0, 0);

      // Reset mid-frame: outputs return to reset values and no result appears
      p0 = pc1;
      frame_q.delete();
      for (int j = 0; j < 10; j++) frame_q.push_back(8'($urandom_range(1, 255)));
      send_frame(1'b0, 1'b0, 3);
      rst_n = 1'b0;
      #1;
      check("mrst_ready", rdy1, 0);
      check("mrst_valid", rv1, 0);
      check("mrst_csum1", cs1, 0);
      check("mrst_csum4", cs4, 0);
      check("mrst_ok4", ok4, 0);
      check("mrst_len1", len1, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      check("mrst_ready_after", rdy1, 1);
      check("mrst_pulses", pc1 - p0, 0);
      expect_model(1'b0, ec, eok, el);
      send_frame(1'b0, 1'b0, -1);
      wait_result(ec, eok, el, "after_rst");

      // Length boundary: exactly 65535 bytes, then one beat past the limit
      frame_q.delete();
      for (int j = 0; j < 65535; j++) frame_q.push_back(8'h00);
      expect_model(1'b0, ec, eok, el);
      send_frame(1'b1, 1'b0, -1);
      wait_result(ec, eok, el, "len_max");
      for (int j = 0; j < 5; j++) frame_q.push_back(8'h00);
      expect_model(1'b0, ec, eok, el);
      send_frame(1'b1, 1'b0, -1);
      wait_result(ec, eok, el, "len_ovf");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "bench timeout");
   end

endmodule

// File: doc/udp_csum_engine.md
# udp_csum_engine

Parametrised streaming UDP checksum engine; successor to the fixed 22-byte, serial checksum calculate/validate pair. Accepts a UDP datagram (header + payload) as a byte-lane stream of configurable width and any length up to 65535 bytes. Computes the RFC 768/1071 16-bit one's-complement checksum in either generate or verify mode. Sits between the UDP/IP rx/tx framers and the checksum consumers.

## Interface
- BYTES_PER_BEAT, 1: byte lanes per beat; legal values 1, 2, 4, 8; byte 0 in the MSBs of in_data.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- mode  in  1  0 = generate, 1 = verify; sampled on the first beat only.
- in_data  in  8*BYTES_PER_BEAT  datagram bytes.
- in_keep  in  BYTES_PER_BEAT  valid-byte mask, contiguous from MSB lane; all ones except possibly on the last beat.
- in_valid / in_first / in_last  in  1 each  beat qualifiers.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- src_ip, dst_ip  in  32 each  pseudo-header addresses; sampled on first beat; present only with UDP_CSUM_PSEUDO_HDR_EN.
- result_valid  out  1  one-cycle pulse.
- result_csum  out  16  generate: checksum to insert; verify: ~folded sum.
- result_ok  out  1  verify: checksum correct and no overflow; generate: no overflow.
- result_len  out  16  counted datagram bytes, saturating.

## Operation
- States: IDLE, ACCUM, PSEUDO (macro only), FOLD1, FOLD2, DONE.
- IDLE: in_ready=1. A beat without in_first is dropped. A beat with in_first clears the accumulator (32 bits), byte count and parity, latches mode/IPs, accumulates the beat, then goes to ACCUM; a first+last beat goes directly to the next state.
- ACCUM: in_ready=1. Each accepted beat adds its kept bytes. A byte at an even stream offset goes to bits 15:8 of a word, an odd offset to bits 7:0. The parity bit carries across beats, so odd byte counts per beat are legal. The byte count adds popcount(in_keep). When in_last is set, go to PSEUDO, or to FOLD1 if the macro is off.
- in_first in ACCUM: the current frame is aborted with no result, and the beat starts a new frame.
- Byte count above 65535: saturate result_len to 0xFFFF, set a sticky overflow flag, and keep consuming until in_last.
- PSEUDO: add src_ip[31:16], src_ip[15:0], dst_ip[31:16], dst_ip[15:0], 0x0011, and the byte count.
- FOLD1/FOLD2: acc = acc[15:0] + acc[31:16], performed twice. The result is a 16-bit sum S.
- DONE: result_valid=1.
  - Generate: result_csum = ~S, with 0x0000 replaced by 0xFFFF.
  - Verify: result_csum = ~S; result_ok = (S==0xFFFF) && !overflow.
  - Then return to IDLE.
- In generate mode the stream's checksum field must be zero; the engine does not mask it.

## Timing
- in_ready is 0 from the cycle after the last beat is accepted through the DONE cycle. It is 1 otherwise, including in IDLE out of reset.
- Last beat accepted at cycle T. result_valid is high at T+4 with the macro, or T+3 without it.
- Result outputs hold their values until the next DONE. No downstream backpressure.
- Reset values: in_ready=0 while rst_n is low, then 1. result_valid=0, result_csum=0x0000, result_ok=0, result_len=0x0000.
- Reset asserted mid-frame: the frame is discarded and no result is produced.

## Configuration
- UDP_CSUM_PSEUDO_HDR_EN defined: the src_ip/dst_ip ports exist, PSEUDO is active, and latency is T+4.
- UDP_CSUM_PSEUDO_HDR_EN undefined: the ports are absent, the PSEUDO state is omitted, only header and payload are summed, and latency is T+3.

## Structure
- Package udp_pkg holds:
  - IP_PROTO_UDP = 8'h11.
  - MAX_UDP_LEN = 16'hFFFF.
  - The state enum.
  - A function csum_add16 implementing a 16-bit end-around-carry add.
- Sub-module udp_csum_beat_sum: combinational. Takes in_data, in_keep and the parity-in bit; outputs the beat's partial sum (19 bits), the byte count and the parity-out bit.

## Test plan
- Macro off, BYTES_PER_BEAT=1, generate, bytes 00 01 F2 03 F4 F5 F6 F7 -> result_csum=0x220D, result_len=8, result_ok=1, result_valid at T+3. Repeat with BYTES_PER_BEAT=4 (two beats) -> identical result.
- Macro off, verify, the same 8 bytes followed by 22 0D -> result_ok=1, result_csum=0x0000. Corrupt the last byte to 0E -> result_ok=0.
- Macro off, BYTES_PER_BEAT=2, odd length 01 02 03 with last in_keep=2'b10 -> result_csum=0xFBFD, result_len=3. Stream FF FF -> result_csum=0xFFFF (zero substitution).
- Macro on, generate, src_ip=0x0A000001, dst_ip=0x0A000002, 8 zero bytes -> result_csum=0xEBE3, result_valid at T+4.
- Abort and reset: in_first reasserted mid-frame -> only the second frame's result appears. rst_n pulsed mid-frame -> no result_valid, all outputs at reset values, next frame correct.
